// File: rtl/hgcal_input_quantizer.sv
// Quantizes a serial stream of signed samples to 2-bit codes and packs one frame into a handshaked output register.
// Optional frame-length checking against in_last is enabled by defining HGCAL_QUANT_FRAME_CHECK_EN.
module hgcal_input_quantizer #(
   parameter int                     NUM_IN = 24,
   parameter int                     IN_W   = 16,
   parameter logic signed [IN_W-1:0] T0     = -16'sd512,
   parameter logic signed [IN_W-1:0] T1     = 16'sd0,
   parameter logic signed [IN_W-1:0] T2     = 16'sd512
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic signed [IN_W-1:0] in_data,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [2*NUM_IN-1:0]    out_vec,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [15:0]            frame_cnt,
   output logic                   err
);

   localparam int                IDX_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int                VEC_W    = 2 * NUM_IN;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_IN - 1);

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_HOLD = 2'd1,
      ST_SKIP = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [VEC_W-1:0]   fill_q, fill_d;
   logic [VEC_W-1:0]   out_vec_q, out_vec_d;
   logic               out_valid_q, out_valid_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic               err_q, err_d;

   logic               accept_s;
   logic               slot_free_s;
   logic               at_last_s;
   logic               xfer_s;
   logic [1:0]         code_s;

   function automatic logic [1:0] quantize(input logic signed [IN_W-1:0] x);
      logic [1:0] c;
      if (x < T0) begin
         c = 2'd0;
      end else if (x < T1) begin
         c = 2'd1;
      end else if (x < T2) begin
         c = 2'd2;
      end else begin
         c = 2'd3;
      end
      return c;
   endfunction

   // in_ready is a pure decode of the state register, so it never depends on out_ready.
   assign in_ready    = (state_q != ST_HOLD);
   assign accept_s    = in_valid && in_ready;
   assign slot_free_s = !out_valid_q || out_ready;
   assign at_last_s   = (idx_q == LAST_IDX);
   assign code_s      = quantize(in_data);

   // Fill-buffer sequencing, frame completion and framing-error detection.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      fill_d  = fill_q;
      err_d   = err_q;
      xfer_s  = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (accept_s) begin
               fill_d[{idx_q, 1'b0} +: 2] = code_s;
`ifdef HGCAL_QUANT_FRAME_CHECK_EN
               if (in_last && !at_last_s) begin
                  err_d = 1'b1;
                  idx_d = '0;
               end else if (!in_last && at_last_s) begin
                  err_d   = 1'b1;
                  idx_d   = '0;
                  state_d = ST_SKIP;
               end else
`endif
               if (at_last_s) begin
                  if (slot_free_s) begin
                     xfer_s = 1'b1;
                     idx_d  = '0;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_HOLD: begin
            if (slot_free_s) begin
               xfer_s  = 1'b1;
               idx_d   = '0;
               state_d = ST_FILL;
            end else begin
               state_d = ST_HOLD;
            end
         end
`ifdef HGCAL_QUANT_FRAME_CHECK_EN
         ST_SKIP: begin
            if (accept_s && in_last) begin
               idx_d   = '0;
               state_d = ST_FILL;
            end else begin
               state_d = ST_SKIP;
            end
         end
`endif
         default: begin
            idx_d   = '0;
            state_d = ST_FILL;
         end
      endcase
   end

   // Output register: a transfer wins over a drain, so drain+transfer keeps out_valid high.
   always_comb begin
      out_vec_d   = out_vec_q;
      out_valid_d = out_valid_q;
      frame_cnt_d = frame_cnt_q;
      if (xfer_s) begin
         out_vec_d   = fill_d;
         out_valid_d = 1'b1;
         frame_cnt_d = frame_cnt_q + 16'd1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State, fill buffer and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FILL;
         idx_q       <= '0;
         fill_q      <= '0;
         out_vec_q   <= '0;
         out_valid_q <= 1'b0;
         frame_cnt_q <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         fill_q      <= fill_d;
         out_vec_q   <= out_vec_d;
         out_valid_q <= out_valid_d;
         frame_cnt_q <= frame_cnt_d;
         err_q       <= err_d;
      end
   end

   assign out_vec   = out_vec_q;
   assign out_valid = out_valid_q;
   assign frame_cnt = frame_cnt_q;

`ifdef HGCAL_QUANT_FRAME_CHECK_EN
   assign err = err_q;
`else
   logic unused_in_last_s;
   logic unused_err_s;
   assign unused_in_last_s = in_last;
   assign unused_err_s     = err_q;
   assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Directed, table-driven bench for hgcal_input_quantizer; covers both builds of HGCAL_QUANT_FRAME_CHECK_EN.
module tb_hgcal_input_quantizer;

   localparam int NUM_IN = 24;
   localparam int NTBL   = 10;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic signed [15:0]   in_data;
   logic                 in_valid;
   logic                 in_last;
   logic                 in_ready;
   logic [2*NUM_IN-1:0]  out_vec;
   logic                 out_valid;
   logic                 out_ready;
   logic [15:0]          frame_cnt;
   logic                 err;

   typedef struct {
      logic signed [15:0] x;
      logic [1:0]         code;
   } vec_t;

   vec_t tbl [NTBL];
   int   n_cmp = 0;
   int   n_bad = 0;

   hgcal_input_quantizer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_vec   (out_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_cnt (frame_cnt),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2*NUM_IN-1:0] frame_exp(input int off, input int per);
      logic [2*NUM_IN-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_IN; i++) v[2*i +: 2] = tbl[(off + i) % per].code;
      return v;
   endfunction

   // Drives cnt consecutive samples; in_last is raised on local index last_at (-1 for none).
   task automatic send(input int off, input int per, input int cnt, input int last_at);
      for (int k = 0; k < cnt; k++) begin
         in_data  = tbl[(off + k) % per].x;
         in_last  = (k == last_at);
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      tbl[0] = '{-16'sd1000,  2'd0};
      tbl[1] = '{-16'sd512,   2'd1};
      tbl[2] = '{16'sd0,      2'd2};
      tbl[3] = '{16'sd511,    2'd2};
      tbl[4] = '{16'sd512,    2'd3};
      tbl[5] = '{-16'sd513,   2'd0};
      tbl[6] = '{-16'sd1,     2'd1};
      tbl[7] = '{16'sd32767,  2'd3};
      tbl[8] = '{16'sh8000,   2'd0};
      tbl[9] = '{-16'sd511,   2'd1};

      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 16'sd0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_vec", out_vec, 48'd0);
      chk("rst_frame_cnt", frame_cnt, 16'd0);
      chk("rst_err", err, 1'b0);

      // Frame 1: basic quantization pattern, consumer ready.
      out_ready = 1'b1;
      send(0, 5, NUM_IN - 1, -1);
      chk("f1_pre_valid", out_valid, 1'b0);
      send(NUM_IN - 1, 5, 1, 0);
      chk("f1_valid", out_valid, 1'b1);
      chk("f1_vec", out_vec, frame_exp(0, 5));
      chk("f1_cnt", frame_cnt, 16'd1);

      // Frame 2 completes while frame 1 is still held: HOLD.
      out_ready = 1'b0;
      send(0, NTBL, NUM_IN, NUM_IN - 1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_vec", out_vec, frame_exp(0, 5));
      repeat (3) @(posedge clk);
      #1;
      chk("hold_vec_stable", out_vec, frame_exp(0, 5));
      chk("hold_in_ready_stable", in_ready, 1'b0);
      chk("hold_cnt", frame_cnt, 16'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("swap_vec", out_vec, frame_exp(0, NTBL));
      chk("swap_valid", out_valid, 1'b1);
      chk("swap_cnt", frame_cnt, 16'd2);
      chk("swap_in_ready", in_ready, 1'b1);

      // Drain and transfer on the same edge.
      send(3, NTBL, NUM_IN - 1, -1);
      chk("dt_pre_vec", out_vec, frame_exp(0, NTBL));
      out_ready = 1'b1;
      send(3 + NUM_IN - 1, NTBL, 1, 0);
      chk("dt_valid", out_valid, 1'b1);
      chk("dt_vec", out_vec, frame_exp(3, NTBL));
      chk("dt_cnt", frame_cnt, 16'd3);
      @(posedge clk);
      #1;
      chk("drain_valid", out_valid, 1'b0);

`ifdef HGCAL_QUANT_FRAME_CHECK_EN
      // Short frame: in_last at idx 5.
      send(0, NTBL, 6, 5);
      chk("short_err", err, 1'b1);
      chk("short_valid", out_valid, 1'b0);
      chk("short_cnt", frame_cnt, 16'd3);
      send(5, NTBL, NUM_IN, NUM_IN - 1);
      chk("after_short_vec", out_vec, frame_exp(5, NTBL));
      chk("after_short_cnt", frame_cnt, 16'd4);
      // Long frame: no in_last at the final slot, then 3 extra samples.
      send(0, NTBL, NUM_IN, -1);
      chk("long_valid", out_valid, 1'b0);
      chk("long_cnt", frame_cnt, 16'd4);
      chk("long_err", err, 1'b1);
      send(0, NTBL, 3, 2);
      chk("skip_valid", out_valid, 1'b0);
      chk("skip_cnt", frame_cnt, 16'd4);
      out_ready = 1'b0;
      send(7, NTBL, NUM_IN, NUM_IN - 1);
      chk("after_skip_vec", out_vec, frame_exp(7, NTBL));
      chk("after_skip_cnt", frame_cnt, 16'd5);
      chk("err_sticky", err, 1'b1);
      send(0, NTBL, 10, -1);
`else
      // Same long-frame stimulus without checking: frames are delimited by count.
      out_ready = 1'b0;
      send(1, NTBL, NUM_IN, -1);
      chk("nm_long_vec", out_vec, frame_exp(1, NTBL));
      chk("nm_long_cnt", frame_cnt, 16'd4);
      chk("nm_long_err", err, 1'b0);
      send(0, NTBL, 3, 2);
      send(3, NTBL, 7, -1);
      chk("nm_extra_cnt", frame_cnt, 16'd4);
      chk("nm_extra_vec", out_vec, frame_exp(1, NTBL));
`endif

      // Reset mid-frame at idx 10 while out_valid is high.
      chk("pre_rst_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_vec", out_vec, 48'd0);
      chk("mid_rst_cnt", frame_cnt, 16'd0);
      chk("mid_rst_err", err, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(2, NTBL, NUM_IN - 1, -1);
      chk("post_rst_pre_valid", out_valid, 1'b0);
      send(2 + NUM_IN - 1, NTBL, 1, 0);
      chk("post_rst_vec", out_vec, frame_exp(2, NTBL));
      chk("post_rst_cnt", frame_cnt, 16'd1);
      chk("post_rst_valid", out_valid, 1'b1);
      chk("post_rst_err", err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
